// File: rtl/tdw_mult_arbiter_pkg.sv
// Shared constants and helpers for the twiddle-multiplier arbiter slice.
// Latency: none, this package only holds types, constants and functions.
// Backpressure: not applicable.
package tdw_mult_arbiter_pkg;

  // Default operand widths for the butterfly array.
  localparam int NBITS_DEF      = 10;
  localparam int NBITSCOEFF_DEF = 11;

  // Complex words are packed {real, imag}, with the real part in the upper half.
  localparam bit CPLX_REAL_HI = 1'b1;

  // Index width for a lane count. It never returns less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multip_tdw.sv
// Combinational complex multiply of a sample by a twiddle coefficient, at full precision.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller owns the registers on both sides.
module multip_tdw
  import tdw_mult_arbiter_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int NBITScoeff = NBITSCOEFF_DEF,
  parameter int NBITS_out  = NBITS + NBITScoeff
) (
  input  logic [2*NBITS-1:0]      muestra,
  input  logic [2*NBITScoeff-1:0] coeff,
  output logic [2*NBITS_out-1:0]  producto
);

  localparam int M_RE = CPLX_REAL_HI ? NBITS : 0;
  localparam int M_IM = CPLX_REAL_HI ? 0 : NBITS;
  localparam int C_RE = CPLX_REAL_HI ? NBITScoeff : 0;
  localparam int C_IM = CPLX_REAL_HI ? 0 : NBITScoeff;
  localparam int P_RE = CPLX_REAL_HI ? NBITS_out : 0;
  localparam int P_IM = CPLX_REAL_HI ? 0 : NBITS_out;

  // Operands are sign-extended to the product width first, so no partial product is truncated.
  logic signed [NBITS_out-1:0] mr, mi, cr, ci, pr, pi;

  assign mr = NBITS_out'($signed(muestra[M_RE +: NBITS]));
  assign mi = NBITS_out'($signed(muestra[M_IM +: NBITS]));
  assign cr = NBITS_out'($signed(coeff[C_RE +: NBITScoeff]));
  assign ci = NBITS_out'($signed(coeff[C_IM +: NBITScoeff]));

  assign pr = mr * cr - mi * ci;
  assign pi = mr * ci + mi * cr;

  assign producto[P_RE +: NBITS_out] = pr;
  assign producto[P_IM +: NBITS_out] = pi;

endmodule

// File: rtl/tdw_mult_arbiter.sv
// Round-robin share of one complex twiddle multiplier among NLANES requester lanes.
// Latency: LAT cycles from request transfer to res_valid, plus any stall cycles.
// Backpressure: res_valid & ~res_ready freezes every stage and forces req_ready to zero.
module tdw_mult_arbiter
  import tdw_mult_arbiter_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int NBITScoeff = NBITSCOEFF_DEF,
  parameter int NBITS_out  = NBITS + NBITScoeff,
  parameter int NLANES     = 4,
  parameter int LAT        = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NLANES-1:0]              req_valid,
  output logic [NLANES-1:0]              req_ready,
  input  logic [NLANES*2*NBITS-1:0]      req_muestra,
  input  logic [NLANES*2*NBITScoeff-1:0] req_coeff,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [clog2(NLANES)-1:0]       res_lane,
  output logic [NLANES-1:0]              res_strobe,
  output logic [2*NBITS_out-1:0]         res_data
);

  localparam int LW = clog2(NLANES);
  localparam int MW = 2*NBITS;
  localparam int CW = 2*NBITScoeff;
  localparam int PW = 2*NBITS_out;

  typedef struct packed {
    logic          vld;
    logic [LW-1:0] lane;
    logic [MW-1:0] muestra;
    logic [CW-1:0] coeff;
  } s1_t;

  typedef struct packed {
    logic          vld;
    logic [LW-1:0] lane;
    logic [PW-1:0] data;
  } tail_t;

  logic [LW-1:0]     rr_ptr;
  logic [NLANES-1:0] grant;
  logic [LW-1:0]     gnt_idx;
  logic [LW-1:0]     cand;
  logic [MW-1:0]     gnt_muestra;
  logic [CW-1:0]     gnt_coeff;
  logic              stall;
  s1_t               s1;
  logic [PW-1:0]     prod;

  assign stall = res_valid & ~res_ready;

  // Scan from the farthest lane to the nearest one, so the valid lane closest to the pointer wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NLANES-1; i >= 0; i--) begin
      cand = LW'((int'(rr_ptr) + i) % NLANES);
      if (req_valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  // Reset holds ready low as well, so no handshake completes while the block is held.
  assign req_ready = (rst_n && !stall) ? grant : '0;

  // AND-OR select of the granted lane's operands; lanes that are not granted contribute zero.
  always_comb begin
    gnt_muestra = '0;
    gnt_coeff   = '0;
    for (int i = 0; i < NLANES; i++) begin
      gnt_muestra = gnt_muestra | (req_muestra[i*MW +: MW] & {MW{req_ready[i]}});
      gnt_coeff   = gnt_coeff   | (req_coeff[i*CW +: CW]   & {CW{req_ready[i]}});
    end
  end

  // Move the pointer to the lane after the winner; hold it when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (|req_ready) begin
      rr_ptr <= (gnt_idx == LW'(NLANES-1)) ? '0 : gnt_idx + LW'(1);
    end
  end

  // Stage 1 captures the grant. A cycle with no grant loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (!stall) begin
      s1.vld     <= |req_ready;
      s1.lane    <= gnt_idx;
      s1.muestra <= gnt_muestra;
      s1.coeff   <= gnt_coeff;
    end
  end

  multip_tdw #(
    .NBITS      (NBITS),
    .NBITScoeff (NBITScoeff),
    .NBITS_out  (NBITS_out)
  ) u_mult (
    .muestra  (s1.muestra),
    .coeff    (s1.coeff),
    .producto (prod)
  );

  generate
    if (LAT == 1) begin : g_direct
      assign res_valid = s1.vld;
      assign res_lane  = s1.lane;
      assign res_data  = prod;
    end else begin : g_pipe
      tail_t tail [LAT-1];

      // Stages 2..LAT shift together and freeze as one on a stall.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT-1; i++) tail[i] <= '0;
        end else if (!stall) begin
          tail[0] <= '{vld: s1.vld, lane: s1.lane, data: prod};
          for (int i = 1; i < LAT-1; i++) tail[i] <= tail[i-1];
        end
      end

      assign res_valid = tail[LAT-2].vld;
      assign res_lane  = tail[LAT-2].lane;
      assign res_data  = tail[LAT-2].data;
    end
  endgenerate

  // One-hot of the issuing lane, and zero when no result is valid.
  always_comb begin
    res_strobe = '0;
    if (res_valid) res_strobe[res_lane] = 1'b1;
  end

endmodule

// File: tb/tb_tdw_mult_arbiter.sv
// Bench for tdw_mult_arbiter: directed stimulus plus a queue model checked on every negedge.
// Latency: the model expects each result LAT cycles after its grant, plus any stall cycles.
// Backpressure: res_ready is driven low for a window while results are in flight.
module tb_tdw_mult_arbiter;

  localparam int NL  = 4;
  localparam int LAT = 2;
  localparam int NB  = 10;
  localparam int NC  = 11;
  localparam int NO  = NB + NC;
  localparam int LW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NL-1:0]       req_valid;
  logic [NL-1:0]       req_ready;
  logic [NL*2*NB-1:0]  req_muestra;
  logic [NL*2*NC-1:0]  req_coeff;
  logic                res_valid;
  logic                res_ready;
  logic [LW-1:0]       res_lane;
  logic [NL-1:0]       res_strobe;
  logic [2*NO-1:0]     res_data;

  tdw_mult_arbiter #(
    .NBITS(NB), .NBITScoeff(NC), .NBITS_out(NO), .NLANES(NL), .LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_muestra(req_muestra), .req_coeff(req_coeff),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_lane(res_lane), .res_strobe(res_strobe), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int              lane;
    logic [2*NO-1:0] dat;
    int              cyc;
    int              sc;
  } ent_t;

  ent_t q[$];
  int   mptr = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   iss_cnt = 0;
  int   rx_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [NL-1:0] onehot(input int k);
    logic [NL-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // The winner is the valid lane at the shortest forward distance from the pointer.
  function automatic int model_grant(input logic [NL-1:0] v, input int p);
    for (int d = 0; d < NL; d++)
      if (v[(p + d) % NL]) return (p + d) % NL;
    return -1;
  endfunction

  // Complex product computed in integer arithmetic, then packed {re, im} into NO-bit fields.
  function automatic logic [2*NO-1:0] cmul(input logic [2*NB-1:0] m, input logic [2*NC-1:0] c);
    int mr, mi, cr, ci, re, im;
    logic [NO-1:0] r, i_;
    mr = int'($signed(m[2*NB-1:NB]));
    mi = int'($signed(m[NB-1:0]));
    cr = int'($signed(c[2*NC-1:NC]));
    ci = int'($signed(c[NC-1:0]));
    re = mr*cr - mi*ci;
    im = mr*ci + mi*cr;
    r  = re[NO-1:0];
    i_ = im[NO-1:0];
    return {r, i_};
  endfunction

  task automatic set_lane(input int k, input bit v, input logic [2*NB-1:0] m, input logic [2*NC-1:0] c);
    req_valid[k] = v;
    req_muestra[k*2*NB +: 2*NB] = m;
    req_coeff[k*2*NC +: 2*NC] = c;
  endtask

  task automatic idle_lanes();
    for (int k = 0; k < NL; k++) set_lane(k, 1'b0, (2*NB)'($urandom), (2*NC)'($urandom));
  endtask

  task automatic all_valid();
    for (int k = 0; k < NL; k++) set_lane(k, 1'b1, (2*NB)'($urandom), (2*NC)'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model and compare process: every negedge, check the outputs, then account for the coming edge.
  logic          st;
  int            g;
  logic [NL-1:0] er;
  ent_t          e;
  logic          prev_stall = 1'b0;
  logic [2*NO-1:0] prev_data;
  logic [LW-1:0] prev_lane;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_res_valid", res_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_lane", res_lane, 0);
        chk("rst_res_strobe", res_strobe, 0);
        q.delete();
        mptr = 0;
        prev_stall = 1'b0;
      end else begin
        st = res_valid && !res_ready;
        g  = st ? -1 : model_grant(req_valid, mptr);
        er = (g < 0) ? '0 : onehot(g);
        chk("req_ready", req_ready, er);
        if (res_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL res_unexpected: got res_valid=1 lane=%0d want no result", res_lane);
          end else begin
            e = q[0];
            chk("res_lane", res_lane, e.lane);
            chk("res_data", res_data, e.dat);
            chk("res_strobe", res_strobe, onehot(e.lane));
            if (prev_stall) begin
              chk("hold_data", res_data, prev_data);
              chk("hold_lane", res_lane, prev_lane);
            end else begin
              chk("latency", cyc - e.cyc - (stall_cnt - e.sc), LAT);
            end
          end
        end else begin
          chk("idle_strobe", res_strobe, 0);
        end
        if (res_valid && res_ready && q.size() > 0) begin
          void'(q.pop_front());
          rx_cnt++;
        end
        if (g >= 0) begin
          e.lane = g;
          e.dat  = cmul(req_muestra[g*2*NB +: 2*NB], req_coeff[g*2*NC +: 2*NC]);
          e.cyc  = cyc;
          e.sc   = stall_cnt;
          q.push_back(e);
          iss_cnt++;
          mptr = (g + 1) % NL;
        end
        if (st) stall_cnt++;
        prev_stall = st;
        prev_data  = res_data;
        prev_lane  = res_lane;
      end
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  int n_iss, nstall, base_rx, base_iss, w;

  initial begin
    rst_n = 1'b0;
    res_ready = 1'b1;
    req_valid = '0;
    req_muestra = '0;
    req_coeff = '0;
    all_valid();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_gated", req_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    idle_lanes();
    rst_n = 1'b1;
    tick();

    // Single lane 2: {3,-4} x {5,2} = {23,-14}
    set_lane(2, 1'b1, {10'd3, 10'h3FC}, {11'd5, 11'd2});
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    tick();
    idle_lanes();
    chk("single_early", res_valid, 0);
    tick();
    chk("single_valid", res_valid, 1);
    chk("single_data", res_data, {21'd23, 21'h1FFFF2});
    chk("single_lane", res_lane, 2);
    chk("single_strobe", res_strobe, 4'b0100);
    repeat (3) tick();

    // All lanes valid: the pointer sits at 3, so grants run 3,0,1,2,... and results follow LAT later
    base_rx = rx_cnt;
    for (int i = 0; i < 12; i++) begin
      all_valid();
      @(negedge clk);
      chk("rr_grant", req_ready, onehot((3 + i) % NL));
      if (i >= LAT) begin
        chk("rr_res_valid", res_valid, 1);
        chk("rr_res_lane", res_lane, (3 + i - LAT) % NL);
      end
      tick();
    end
    idle_lanes();
    repeat (LAT + 2) tick();
    chk("rr_count", rx_cnt - base_rx, 12);

    // Fairness: lane 1 alone moves the pointer to 2; then lanes 1 and 3, with lane 0 held until served
    set_lane(1, 1'b1, (2*NB)'($urandom), (2*NC)'($urandom));
    @(negedge clk);
    chk("fair_setup", req_ready, 4'b0010);
    tick();
    set_lane(0, 1'b1, (2*NB)'($urandom), (2*NC)'($urandom));
    set_lane(1, 1'b1, (2*NB)'($urandom), (2*NC)'($urandom));
    set_lane(3, 1'b1, (2*NB)'($urandom), (2*NC)'($urandom));
    @(negedge clk);
    chk("fair_g3", req_ready, 4'b1000);
    tick();
    @(negedge clk);
    chk("fair_g0", req_ready, 4'b0001);
    tick();
    set_lane(0, 1'b0, (2*NB)'($urandom), (2*NC)'($urandom));
    @(negedge clk);
    chk("fair_g1", req_ready, 4'b0010);
    tick();
    @(negedge clk);
    chk("fair_g3b", req_ready, 4'b1000);
    tick();
    idle_lanes();
    repeat (4) tick();

    // Backpressure: res_ready low for cycles 3..5 while requests stream; 8 issued must equal 8 received
    base_rx = rx_cnt;
    base_iss = iss_cnt;
    n_iss = 0;
    nstall = 0;
    w = 0;
    while (n_iss < 8 && w < 40) begin
      all_valid();
      res_ready = !(w >= 3 && w < 6);
      @(negedge clk);
      if (res_valid && !res_ready) begin
        nstall++;
        chk("bp_ready_zero", req_ready, 0);
      end
      if (|req_ready) n_iss++;
      tick();
      w++;
    end
    idle_lanes();
    res_ready = 1'b1;
    repeat (6) tick();
    chk("bp_stall_cycles", nstall, 3);
    chk("bp_issued", iss_cnt - base_iss, 8);
    chk("bp_received", rx_cnt - base_rx, 8);

    // Extremes: {-512,-512} x {-1024,-1024} gives re 0 and im 2^20 as a raw 21-bit field
    set_lane(1, 1'b1, {10'h200, 10'h200}, {11'h400, 11'h400});
    @(negedge clk);
    chk("ext_ready", req_ready, 4'b0010);
    tick();
    idle_lanes();
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!res_valid && w < 10);
    chk("ext_seen", res_valid, 1);
    chk("ext_data", res_data, {21'd0, 21'h100000});
    tick();
    repeat (3) tick();

    // Reset mid-stream: three grants leave two results in flight and the pointer at 1
    all_valid();
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_res_lane", res_lane, 0);
    chk("mid_rst_res_strobe", res_strobe, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    idle_lanes();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", res_valid, 0);
    end
    @(posedge clk);
    #1;
    set_lane(0, 1'b1, (2*NB)'($urandom), (2*NC)'($urandom));
    set_lane(2, 1'b1, (2*NB)'($urandom), (2*NC)'($urandom));
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    tick();
    idle_lanes();
    repeat (5) tick();
    chk("final_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
